// File: rtl/codec_i2c_config_if.sv
// Control/status bundle between the audio top level and the codec configurator.
// Latency: none, wires only.
// Backpressure: none; start is a one-cycle request, busy/done/error report progress.
//   start : request pulse into the configurator
//   sca   : I2C SCL, push-pull
//   busy  : sequence in progress
//   done  : sticky, all register words written
//   error : sticky, a slave NACK aborted the sequence
interface codec_i2c_config_if;
    logic start;
    logic sca;
    logic busy;
    logic done;
    logic error;

    modport master (input start, output sca, busy, done, error);
    modport slave  (output start, input sca, busy, done, error);
endinterface

// File: rtl/codec_i2c_config.sv
// Writes a fixed 8-word WM8731-class register table over I2C on start, then raises done.
// Latency: busy the cycle after start; done 960*DIV clocks later (120 quarter-bit ticks per word).
// Backpressure: none; start is ignored while busy. Optional macro CODEC_ACK_CHECK_EN enables NACK abort.
//   clk, reset : system clock, asynchronous active-low reset
//   sda        : I2C SDA, open-drain (drives 0 or z)
//   bus        : start in; sca, busy, done, error out
module codec_i2c_config #(
    parameter logic [31:0] CLOCK_SPEED = 32'd50000000,
    parameter logic [31:0] I2C_SPEED   = 32'd100000,
    parameter logic [6:0]  DEV_ADDR    = 7'h1A
) (
    input  logic               clk,
    input  logic               reset,
    inout  wire                sda,
    codec_i2c_config_if.master bus
);
    // Quarter-bit period in clocks; must be at least 1.
    localparam logic [31:0] DIV = CLOCK_SPEED / (32'd4 * I2C_SPEED);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_BIT   = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [1:0]  ph_q, ph_d;        // quarter phase q0..q3 within a symbol
    logic [2:0]  bit_q, bit_d;      // bit index within byte, MSB first
    logic [1:0]  byte_q, byte_d;    // 0: address, 1: word high, 2: word low
    logic [2:0]  idx_q, idx_d;      // register table index, 7 is terminal
    logic [31:0] cnt_q, cnt_d;
    logic        scl_q, scl_d;
    logic        oe_q, oe_d;        // 1 pulls SDA low
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        tick;
    logic [15:0] tx_word;
    logic [7:0]  tx_byte;
`ifdef CODEC_ACK_CHECK_EN
    logic        nack_q, nack_d;
    logic        error_q, error_d;
`endif

    function automatic logic [15:0] cfg_word(input logic [2:0] i);
        case (i)
            3'd0:    cfg_word = 16'h1E00;  // reset
            3'd1:    cfg_word = 16'h0C00;  // power on
            3'd2:    cfg_word = 16'h0812;  // DAC select, mic mute
            3'd3:    cfg_word = 16'h0A00;  // DAC unmute
            3'd4:    cfg_word = 16'h0E02;  // I2S, 16-bit, slave
            3'd5:    cfg_word = 16'h1000;  // normal mode, 48 kHz
            3'd6:    cfg_word = 16'h0579;  // headphone 0 dB, both channels
            default: cfg_word = 16'h1201;  // active
        endcase
    endfunction

    assign tick = (cnt_q == DIV - 32'd1);

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        idx_d   = idx_q;
        scl_d   = scl_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef CODEC_ACK_CHECK_EN
        nack_d  = nack_q;
        error_d = error_q;
`endif
        tx_word = 16'h0000;
        tx_byte = 8'h00;
        cnt_d   = cnt_q + 32'd1;
        if (state_q == S_IDLE || state_q == S_FIN || state_q == S_ERR || tick)
            cnt_d = 32'd0;

        if (state_q == S_IDLE) begin
            if (bus.start) begin
                state_d = S_START;
                ph_d    = 2'd0;
                idx_d   = 3'd0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
`ifdef CODEC_ACK_CHECK_EN
                nack_d  = 1'b0;
                error_d = 1'b0;
`endif
            end
        end else if (state_q == S_FIN || state_q == S_ERR) begin
            state_d = S_IDLE;
        end else if (tick) begin
            ph_d = ph_q + 2'd1;
`ifdef CODEC_ACK_CHECK_EN
            // Slave ACK is sampled at the end of q2, mid SCL-high.
            if (state_q == S_ACK && ph_q == 2'd2)
                nack_d = sda;
`endif
            if (ph_q == 2'd3) begin
                case (state_q)
                    S_START: begin
                        state_d = S_BIT;
                        bit_d   = 3'd7;
                        byte_d  = 2'd0;
                    end
                    S_BIT: begin
                        if (bit_q == 3'd0) state_d = S_ACK;
                        else               bit_d   = bit_q - 3'd1;
                    end
                    S_ACK: begin
`ifdef CODEC_ACK_CHECK_EN
                        if (nack_q) state_d = S_STOP;
                        else
`endif
                        if (byte_q == 2'd2) begin
                            state_d = S_STOP;
                        end else begin
                            state_d = S_BIT;
                            bit_d   = 3'd7;
                            byte_d  = byte_q + 2'd1;
                        end
                    end
                    S_STOP: begin
                        state_d = S_GAP;
`ifdef CODEC_ACK_CHECK_EN
                        // A NACKed word still ends with a clean STOP before aborting.
                        if (nack_q) begin
                            state_d = S_ERR;
                            busy_d  = 1'b0;
                            error_d = 1'b1;
                        end
`endif
                    end
                    S_GAP: begin
                        if (idx_q == 3'd7) begin
                            state_d = S_FIN;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_START;
                            idx_d   = idx_q + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end

            // Pin levels for the phase being entered, so pins move only on ticks.
            tx_word = cfg_word(idx_d);
            case (byte_d)
                2'd0:    tx_byte = {DEV_ADDR, 1'b0};
                2'd1:    tx_byte = tx_word[15:8];
                default: tx_byte = tx_word[7:0];
            endcase
            case (state_d)
                S_START: begin scl_d = (ph_d != 2'd3); oe_d = (ph_d != 2'd0); end
                S_BIT:   begin scl_d = ph_d[1];        oe_d = ~tx_byte[bit_d]; end
                S_ACK:   begin scl_d = ph_d[1];        oe_d = 1'b0;            end
                S_STOP:  begin scl_d = (ph_d != 2'd0); oe_d = ~ph_d[1];        end
                default: begin scl_d = 1'b1;           oe_d = 1'b0;            end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ph_q    <= 2'd0;
            bit_q   <= 3'd7;
            byte_q  <= 2'd0;
            idx_q   <= 3'd0;
            cnt_q   <= 32'd0;
            scl_q   <= 1'b1;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            scl_q   <= scl_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef CODEC_ACK_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nack_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            nack_q  <= nack_d;
            error_q <= error_d;
        end
    end
    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    assign sda      = oe_q ? 1'b0 : 1'bz;
    assign bus.sca  = scl_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_codec_i2c_config.sv
// Bench for codec_i2c_config: I2C slave model decodes bytes and checks them against a queue.
// Latency: checks done timing against the 960-tick window at DIV=1.
// Backpressure: slave model ACKs or NACKs per run policy; start pulses mid-run must be ignored.
module tb_codec_i2c_config;
    logic       clk = 1'b0;
    logic       reset;
    wire        sda;
    logic       ack_drv = 1'b0;
    int         cyc = 0;
    int         n_checks, n_fail;
    logic [7:0] exp_q[$];
    int         starts, stops;
    int         fr_base, nack_all, nack_fr, nack_byte;

    logic [15:0] tbl [8] = '{16'h1E00, 16'h0C00, 16'h0812, 16'h0A00,
                             16'h0E02, 16'h1000, 16'h0579, 16'h1201};

    codec_i2c_config_if bus_if();

    codec_i2c_config #(
        .CLOCK_SPEED(32'd400),
        .I2C_SPEED  (32'd100),
        .DEV_ADDR   (7'h1A)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sda  (sda),
        .bus  (bus_if)
    );

    pullup (sda);
    assign sda = ack_drv ? 1'b0 : 1'bz;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Expected byte stream: address 0x34 (0x1A<<1 | W), then the table word, per frame.
    task automatic push_words(input int n);
        for (int w = 0; w < n; w++) begin
            exp_q.push_back(8'h34);
            exp_q.push_back(tbl[w][15:8]);
            exp_q.push_back(tbl[w][7:0]);
        end
    endtask

    // Slave model and byte monitor, sampled on the falling clock edge.
    task automatic monitor();
        logic       p_scl, p_sda, s_scl, s_sda;
        int         bitcnt, bytecnt, fr;
        logic [7:0] shreg, e;
        p_scl = 1'b1; p_sda = 1'b1; bitcnt = 0; bytecnt = 0; shreg = 8'h00;
        forever begin
            @(negedge clk);
            s_scl = bus_if.sca;
            s_sda = sda;
            if (p_scl && s_scl && p_sda && !s_sda) begin
                starts++;
                bitcnt  = 0;
                bytecnt = 0;
            end else if (p_scl && s_scl && !p_sda && s_sda) begin
                stops++;
            end else if (!p_scl && s_scl) begin
                if (bitcnt < 8) begin
                    shreg = {shreg[6:0], s_sda};
                    bitcnt++;
                    if (bitcnt == 8) begin
                        if (exp_q.size() == 0) begin
                            check("extra_byte_seen", {24'd0, shreg}, 32'h100);
                        end else begin
                            e = exp_q.pop_front();
                            check("decoded_byte", {24'd0, shreg}, {24'd0, e});
                        end
                    end
                end else begin
                    bitcnt = 0;
                    bytecnt++;
                end
            end else if (p_scl && !s_scl) begin
                fr = starts - fr_base - 1;
                ack_drv = (bitcnt == 8) &&
                          !(nack_all != 0 || (fr == nack_fr && bytecnt == nack_byte));
            end
            p_scl = s_scl;
            p_sda = s_sda;
        end
    endtask

    // Pulses start, optionally pulses it again restart_at cycles later, waits for done/error.
    task automatic run(input int restart_at, output int lat, output int bcnt, output logic fell_ok);
        int   t0;
        logic pb, fin;
        fr_base = starts;
        @(negedge clk); bus_if.start = 1'b1;
        @(negedge clk); bus_if.start = 1'b0;
        t0 = cyc;
        check("busy_rise", {31'd0, bus_if.busy}, 32'd1);
        check("sda_start_q0", {31'd0, sda}, 32'd1);
        bcnt = 1; pb = 1'b1; fin = 1'b0; lat = 0; fell_ok = 1'b0;
        for (int k = 1; k < 3000 && !fin; k++) begin
            @(negedge clk);
            bus_if.start = (k == restart_at);
            if (k == 1) check("sda_start_q1", {31'd0, sda}, 32'd0);
            if (bus_if.busy) bcnt++;
            if (bus_if.done || bus_if.error) begin
                fin     = 1'b1;
                lat     = cyc - t0;
                fell_ok = pb && !bus_if.busy;
            end
            pb = bus_if.busy;
        end
        bus_if.start = 1'b0;
        if (!fin) check("sequence_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat, bcnt, s0, p0;
        logic ok;
        n_checks = 0; n_fail = 0; starts = 0; stops = 0;
        fr_base = 0; nack_all = 0; nack_fr = -1; nack_byte = -1;
        bus_if.start = 1'b0;
        reset = 1'b0;
        fork
            monitor();
        join_none

        // Reset and idle: {sca, sda, busy, done, error} = 1,1(released),0,0,0
        repeat (5) @(negedge clk);
        check("reset_outputs", {27'd0, bus_if.sca, sda, bus_if.busy, bus_if.done, bus_if.error}, 32'b11000);
        reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_outputs", {27'd0, bus_if.sca, sda, bus_if.busy, bus_if.done, bus_if.error}, 32'b11000);
        end

        // Full sequence, all ACKed, with an ignored start 300 cycles in.
        s0 = starts; p0 = stops;
        push_words(8);
        run(300, lat, bcnt, ok);
        check_range("done_latency", lat, 958, 962);
        check("busy_span", bcnt, lat);
        check("busy_falls_with_done", {31'd0, ok}, 32'd1);
        repeat (5) @(negedge clk);
        check("run1_bytes_left", exp_q.size(), 32'd0);
        check("run1_starts", starts - s0, 32'd8);
        check("run1_stops", stops - p0, 32'd8);
        check("run1_status", {29'd0, bus_if.busy, bus_if.done, bus_if.error}, 32'b010);

        // Second run from IDLE with done=1 and a NACKing slave.
        s0 = starts; p0 = stops;
`ifdef CODEC_ACK_CHECK_EN
        nack_fr = 3; nack_byte = 1;
        push_words(3);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h0A);
        run(0, lat, bcnt, ok);
        repeat (200) @(negedge clk);
        check("nack_status", {29'd0, bus_if.busy, bus_if.done, bus_if.error}, 32'b001);
        check("nack_starts", starts - s0, 32'd4);
        check("nack_stops", stops - p0, 32'd4);
        check("nack_bytes_left", exp_q.size(), 32'd0);
`else
        nack_all = 1;
        push_words(8);
        run(0, lat, bcnt, ok);
        check_range("nack_ignored_latency", lat, 958, 962);
        repeat (5) @(negedge clk);
        check("nack_ignored_status", {29'd0, bus_if.busy, bus_if.done, bus_if.error}, 32'b010);
        check("nack_ignored_starts", starts - s0, 32'd8);
        check("nack_ignored_bytes_left", exp_q.size(), 32'd0);
`endif
        nack_all = 0; nack_fr = -1; nack_byte = -1;

        // Reset 500 cycles into a run (mid word 4), then replay from word 0.
        push_words(4);
        fr_base = starts;
        @(negedge clk); bus_if.start = 1'b1;
        @(negedge clk); bus_if.start = 1'b0;
        repeat (499) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset_mid_sca_sda_busy", {29'd0, bus_if.sca, sda, bus_if.busy}, 32'b110);
        repeat (3) @(negedge clk);
        check("reset_mid_done_error", {30'd0, bus_if.done, bus_if.error}, 32'b00);
        check("reset_mid_bytes_left", exp_q.size(), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        s0 = starts;
        push_words(8);
        run(0, lat, bcnt, ok);
        check_range("replay_latency", lat, 958, 962);
        repeat (5) @(negedge clk);
        check("replay_bytes_left", exp_q.size(), 32'd0);
        check("replay_starts", starts - s0, 32'd8);
        check("replay_status", {29'd0, bus_if.busy, bus_if.done, bus_if.error}, 32'b010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
